// File: rtl/window_3x3_assembler_if.sv
// Window handshake bundle between the 3x3 assembler (master) and the processing element (slave).
interface window_3x3_assembler_if #(
    parameter int PIX_W = 16
);
    logic [9*PIX_W-1:0] window_data;
    logic               window_valid;
    logic               window_ready;

    modport master (
        output window_data,
        output window_valid,
        input  window_ready
    );

    modport slave (
        input  window_data,
        input  window_valid,
        output window_ready
    );
endinterface

// File: rtl/window_3x3_assembler.sv
// Pops three row FIFOs together and registers one 3x3 window per pop for the processing element.
// Optional stall performance counter: define WINDOW_STALL_CNT_EN.
module window_3x3_assembler #(
    parameter int PIX_W = 16,
    parameter int COL_W = 10
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 start,
    input  logic                 stride2en,
    input  logic [COL_W-1:0]     num_cols,
    input  logic [COL_W-1:0]     num_rows,
    input  logic [3*PIX_W-1:0]   row0_data,
    input  logic [3*PIX_W-1:0]   row1_data,
    input  logic [3*PIX_W-1:0]   row2_data,
    input  logic [3:0]           row0_count,
    input  logic [3:0]           row1_count,
    input  logic [3:0]           row2_count,
    output logic                 pop,
    output logic                 one_row_complete,
    window_3x3_assembler_if.master win,
    output logic                 busy,
    output logic                 frame_done,
    output logic [15:0]          stall_cycles
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        RUN     = 2'd1,
        ROW_END = 2'd2
    } state_t;

    state_t             state_r;
    state_t             state_s;
    logic [COL_W-1:0]   cols_r;
    logic [COL_W-1:0]   rows_r;
    logic [COL_W-1:0]   col_cnt_r;
    logic [COL_W-1:0]   row_cnt_r;
    logic [9*PIX_W-1:0] win_data_r;
    logic               win_valid_r;
    logic               busy_r;
    logic               frame_done_r;

    logic               counts_ok_s;
    logic               slot_free_s;
    logic               fire_s;
    logic               row_done_s;
    logic               last_col_s;
    logic               last_row_s;
    logic               unused_s;

    // stride2en only matters to the FIFOs
    assign unused_s = stride2en;

    // Handshake qualifiers; a start in a running frame suppresses the pop that would be thrown away
    always_comb begin
        counts_ok_s = (row0_count >= 4'd3) && (row1_count >= 4'd3) && (row2_count >= 4'd3);
        slot_free_s = ~win_valid_r | win.window_ready;
        fire_s      = (state_r == RUN) && !start && slot_free_s && counts_ok_s;
        row_done_s  = (state_r == ROW_END) && !start && slot_free_s;
        last_col_s  = (col_cnt_r == (cols_r - COL_W'(1)));
        last_row_s  = (row_cnt_r == (rows_r - COL_W'(1)));
    end

    // Next-state decode
    always_comb begin
        state_s = state_r;
        if (start) begin
            state_s = RUN;
        end else begin
            case (state_r)
                IDLE: begin
                    state_s = IDLE;
                end
                RUN: begin
                    if (fire_s && last_col_s) begin
                        state_s = ROW_END;
                    end else begin
                        state_s = RUN;
                    end
                end
                ROW_END: begin
                    if (row_done_s) begin
                        state_s = last_row_s ? IDLE : RUN;
                    end else begin
                        state_s = ROW_END;
                    end
                end
                default: begin
                    state_s = IDLE;
                end
            endcase
        end
    end

    // State register
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Frame sizes, column/row counters and frame status flags
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cols_r       <= {COL_W{1'b0}};
            rows_r       <= {COL_W{1'b0}};
            col_cnt_r    <= {COL_W{1'b0}};
            row_cnt_r    <= {COL_W{1'b0}};
            busy_r       <= 1'b0;
            frame_done_r <= 1'b0;
        end else if (start) begin
            cols_r       <= num_cols;
            rows_r       <= num_rows;
            col_cnt_r    <= {COL_W{1'b0}};
            row_cnt_r    <= {COL_W{1'b0}};
            busy_r       <= 1'b1;
            frame_done_r <= 1'b0;
        end else begin
            frame_done_r <= row_done_s && last_row_s;
            if (fire_s) begin
                col_cnt_r <= last_col_s ? {COL_W{1'b0}} : (col_cnt_r + COL_W'(1));
            end else begin
                col_cnt_r <= col_cnt_r;
            end
            if (row_done_s) begin
                row_cnt_r <= row_cnt_r + COL_W'(1);
            end else begin
                row_cnt_r <= row_cnt_r;
            end
            if (row_done_s && last_row_s) begin
                busy_r <= 1'b0;
            end else begin
                busy_r <= busy_r;
            end
        end
    end

    // Window register: FIFO data_o is sampled in the pop cycle itself
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            win_data_r  <= {(9*PIX_W){1'b0}};
            win_valid_r <= 1'b0;
        end else if (start) begin
            win_data_r  <= win_data_r;
            win_valid_r <= 1'b0;
        end else if (fire_s) begin
            win_data_r  <= {row2_data, row1_data, row0_data};
            win_valid_r <= 1'b1;
        end else if (win.window_ready) begin
            win_data_r  <= win_data_r;
            win_valid_r <= 1'b0;
        end else begin
            win_data_r  <= win_data_r;
            win_valid_r <= win_valid_r;
        end
    end

`ifdef WINDOW_STALL_CNT_EN
    logic [15:0] stall_r;

    // Saturating count of RUN cycles lost to FIFO starvation
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            stall_r <= 16'd0;
        end else if (start) begin
            stall_r <= 16'd0;
        end else if ((state_r == RUN) && slot_free_s && !counts_ok_s && (stall_r != 16'hFFFF)) begin
            stall_r <= stall_r + 16'd1;
        end else begin
            stall_r <= stall_r;
        end
    end

    assign stall_cycles = stall_r;
`else
    assign stall_cycles = 16'd0;
`endif

    assign pop              = fire_s;
    assign one_row_complete = row_done_s;
    assign win.window_data  = win_data_r;
    assign win.window_valid = win_valid_r;
    assign busy             = busy_r;
    assign frame_done       = frame_done_r;

endmodule

// File: tb/tb_window_3x3_assembler.sv
// Directed testbench for window_3x3_assembler with hand-computed expectations.
module tb_window_3x3_assembler;

    localparam int PIX_W = 16;
    localparam int COL_W = 10;

    localparam logic [47:0]  R0_A  = 48'h000300020001;
    localparam logic [47:0]  R1_A  = 48'h000600050004;
    localparam logic [47:0]  R2_A  = 48'h000900080007;
    localparam logic [143:0] WIN_A = 144'h000900080007_000600050004_000300020001;
    localparam logic [47:0]  R0_B  = 48'h00CC00BB00AA;
    localparam logic [47:0]  R1_B  = 48'h00FF00EE00DD;
    localparam logic [47:0]  R2_B  = 48'h012301220121;
    localparam logic [143:0] WIN_B = 144'h012301220121_00FF00EE00DD_00CC00BB00AA;

`ifdef WINDOW_STALL_CNT_EN
    localparam logic [15:0] STALL_EXP = 16'd5;
`else
    localparam logic [15:0] STALL_EXP = 16'd0;
`endif

    logic               clk = 1'b0;
    logic               reset_n;
    logic               start;
    logic               stride2en;
    logic [COL_W-1:0]   num_cols;
    logic [COL_W-1:0]   num_rows;
    logic [3*PIX_W-1:0] row0_data, row1_data, row2_data;
    logic [3:0]         row0_count, row1_count, row2_count;
    logic               pop;
    logic               one_row_complete;
    logic               busy;
    logic               frame_done;
    logic [15:0]        stall_cycles;

    int vec_cnt     = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    window_3x3_assembler_if #(.PIX_W(PIX_W)) win ();

    window_3x3_assembler #(.PIX_W(PIX_W), .COL_W(COL_W)) dut (
        .clk              (clk),
        .reset_n          (reset_n),
        .start            (start),
        .stride2en        (stride2en),
        .num_cols         (num_cols),
        .num_rows         (num_rows),
        .row0_data        (row0_data),
        .row1_data        (row1_data),
        .row2_data        (row2_data),
        .row0_count       (row0_count),
        .row1_count       (row1_count),
        .row2_count       (row2_count),
        .pop              (pop),
        .one_row_complete (one_row_complete),
        .win              (win),
        .busy             (busy),
        .frame_done       (frame_done),
        .stall_cycles     (stall_cycles)
    );

    task automatic chk(input string tag, input logic [143:0] obs, input logic [143:0] exp);
        vec_cnt++;
        if (obs !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic sample();
        @(negedge clk);
    endtask

    function automatic logic [4:0] status();
        return {pop, win.window_valid, one_row_complete, frame_done, busy};
    endfunction

    task automatic set_data(input logic [47:0] d0, input logic [47:0] d1, input logic [47:0] d2);
        row0_data = d0;
        row1_data = d1;
        row2_data = d2;
    endtask

    // Ends at the negedge of the first RUN cycle
    task automatic start_frame(input logic [COL_W-1:0] c, input logic [COL_W-1:0] r);
        next_cycle();
        start    = 1'b1;
        num_cols = c;
        num_rows = r;
        next_cycle();
        start    = 1'b0;
        sample();
    endtask

    task automatic run_until_done(input int max_cyc, output int pops, output int orcs, output int ovl);
        bit done = 1'b0;
        pops = 0;
        orcs = 0;
        ovl  = 0;
        for (int i = 0; i < max_cyc && !done; i++) begin
            next_cycle();
            sample();
            if (pop) pops++;
            if (one_row_complete) orcs++;
            if (pop && one_row_complete) ovl++;
            if (frame_done) done = 1'b1;
        end
        chk("frame_done_seen", {143'd0, done}, 144'd1);
    endtask

    logic [4:0] basic_exp [7] = '{5'b10001, 5'b11001, 5'b11001, 5'b11001,
                                  5'b01101, 5'b00010, 5'b00000};

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int pops, orcs, ovl, p0;
        reset_n          = 1'b0;
        start            = 1'b0;
        stride2en        = 1'b0;
        num_cols         = 10'd0;
        num_rows         = 10'd0;
        row0_count       = 4'd8;
        row1_count       = 4'd8;
        row2_count       = 4'd8;
        win.window_ready = 1'b1;
        set_data(R0_A, R1_A, R2_A);

        // Reset values
        #12;
        chk("reset_status", {139'd0, status()}, 144'd0);
        chk("reset_window_data", win.window_data, 144'd0);
        chk("reset_stall", {128'd0, stall_cycles}, 144'd0);
        next_cycle();
        reset_n = 1'b1;

        // Basic frame: 4 columns, 1 row
        start_frame(10'd4, 10'd1);
        for (int i = 0; i < 7; i++) begin
            if (i > 0) begin
                next_cycle();
                sample();
            end
            chk($sformatf("basic_c%0d", i), {139'd0, status()}, {139'd0, basic_exp[i]});
            if (i == 1) chk("packing", win.window_data, WIN_A);
        end

        // Backpressure: hold window A, then accept it while the next pop fires
        start_frame(10'd4, 10'd1);
        chk("bp_first_pop", {143'd0, pop}, 144'd1);
        next_cycle();
        win.window_ready = 1'b0;
        set_data(R0_B, R1_B, R2_B);
        sample();
        chk("bp_stall_pop", {143'd0, pop}, 144'd0);
        chk("bp_hold_a", win.window_data, WIN_A);
        next_cycle();
        sample();
        chk("bp_stall_pop2", {143'd0, pop}, 144'd0);
        chk("bp_hold_valid", {143'd0, win.window_valid}, 144'd1);
        chk("bp_hold_a2", win.window_data, WIN_A);
        next_cycle();
        win.window_ready = 1'b1;
        sample();
        chk("bp_accept_fire", {143'd0, pop}, 144'd1);
        chk("bp_accept_a", win.window_data, WIN_A);
        next_cycle();
        sample();
        chk("bp_next_b", win.window_data, WIN_B);
        chk("bp_next_valid", {143'd0, win.window_valid}, 144'd1);
        run_until_done(20, pops, orcs, ovl);
        chk("bp_tail_pops", pops, 144'd1);
        chk("bp_orc", orcs, 144'd1);

        // Starvation: middle FIFO short for five RUN cycles
        set_data(R0_A, R1_A, R2_A);
        row1_count = 4'd2;
        start_frame(10'd2, 10'd1);
        for (int i = 0; i < 5; i++) begin
            if (i > 0) begin
                next_cycle();
                sample();
            end
            chk($sformatf("starve_pop_c%0d", i), {143'd0, pop}, 144'd0);
        end
        next_cycle();
        row1_count = 4'd3;
        sample();
        chk("starve_release_pop", {143'd0, pop}, 144'd1);
        chk("starve_stall_cycles", {128'd0, stall_cycles}, {128'd0, STALL_EXP});
        run_until_done(20, pops, orcs, ovl);
        chk("starve_tail_pops", pops, 144'd1);

        // Multi-row: 3 columns x 2 rows
        start_frame(10'd3, 10'd2);
        p0 = pop ? 1 : 0;
        run_until_done(40, pops, orcs, ovl);
        chk("multi_pops", p0 + pops, 144'd6);
        chk("multi_orc", orcs, 144'd2);
        chk("multi_overlap", ovl, 144'd0);
        next_cycle();
        sample();
        chk("multi_fd_once", {143'd0, frame_done}, 144'd0);
        chk("multi_busy_low", {143'd0, busy}, 144'd0);

        // Abort after two windows, then let the restarted frame run out
        start_frame(10'd4, 10'd1);
        next_cycle();
        sample();
        next_cycle();
        start    = 1'b1;
        num_cols = 10'd4;
        num_rows = 10'd1;
        sample();
        next_cycle();
        start = 1'b0;
        sample();
        chk("abort_valid_cleared", {143'd0, win.window_valid}, 144'd0);
        chk("abort_pop", {143'd0, pop}, 144'd1);
        chk("abort_no_fd", {143'd0, frame_done}, 144'd0);
        chk("abort_busy", {143'd0, busy}, 144'd1);
        run_until_done(20, pops, orcs, ovl);
        chk("abort_restart_pops", pops, 144'd3);
        chk("abort_orc", orcs, 144'd1);

        // Asynchronous reset in the middle of a row
        start_frame(10'd4, 10'd2);
        next_cycle();
        sample();
        chk("prereset_status", {139'd0, status()}, {139'd0, 5'b11001});
        #2;
        reset_n = 1'b0;
        #1;
        chk("async_reset_status", {139'd0, status()}, 144'd0);
        chk("async_reset_data", win.window_data, 144'd0);
        chk("async_reset_stall", {128'd0, stall_cycles}, 144'd0);
        next_cycle();
        reset_n = 1'b1;
        next_cycle();

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, miscompares);
        $finish;
    end

endmodule
